carry_save_adder: RTL and testbench



---
 rtl/csa_pkg.sv | 16 +
 rtl/csa_full_adder.sv | 13 +
 rtl/carry_save_adder.sv | 65 ++++++
 tb/tb_carry_save_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and the carry-resolve helper for the carry-save adder.
package csa_pkg;

  localparam int unsigned CSA_DEFAULT_WIDTH = 8;
  // Widest operand the resolve helper supports; callers zero-extend into it.
  localparam int unsigned CSA_MAX_WIDTH     = 64;

  // Resolve a sum/carry pair (carry unshifted) into its full-precision total.
  function automatic logic [CSA_MAX_WIDTH+1:0] csa_resolve(
    input logic [CSA_MAX_WIDTH-1:0] sum,
    input logic [CSA_MAX_WIDTH-1:0] carry
  );
    return {2'b0, sum} + {1'b0, carry, 1'b0};
  endfunction

endpackage

// File: rtl/csa_full_adder.sv
// 1-bit full adder: one column of the 3:2 compressor.
module csa_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/carry_save_adder.sv
// Registered 3-operand carry-save adder (3:2 compressor), 1-cycle latency.
// Define CSA_FINAL_ADD_EN to add the registered resolved `total` output.
module carry_save_adder
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
`ifdef CSA_FINAL_ADD_EN
  ,
  output logic [WIDTH+1:0] total
`endif
);

  logic [WIDTH-1:0] s_w;
  logic [WIDTH-1:0] c_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    csa_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .c  (cin[i]),
      .s  (s_w[i]),
      .co (c_w[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s_w;
        carry <= c_w;
      end
    end
  end

`ifdef CSA_FINAL_ADD_EN
  logic [WIDTH+1:0] total_d;

  // Resolved from the same-cycle compressed values so total shares the sum/carry stage.
  assign total_d = (WIDTH+2)'(csa_resolve(CSA_MAX_WIDTH'(s_w), CSA_MAX_WIDTH'(c_w)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else if (in_valid) begin
      total <= total_d;
    end
  end
`endif

endmodule

// File: tb/tb_carry_save_adder.sv
// Self-checking bench for carry_save_adder: directed vectors, hold/reset, random stream.
module tb_carry_save_adder;

  localparam int unsigned W = 8;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic [W-1:0] cin      = '0;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         out_valid;
`ifdef CSA_FINAL_ADD_EN
  logic [W+1:0] total;
`endif

  int unsigned total_n = 0;
  int unsigned bad_n   = 0;

  always #5 clk = ~clk;

  carry_save_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
`ifdef CSA_FINAL_ADD_EN
    ,
    .total     (total)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Column-wise reference: count the ones in each bit column; parity -> sum, >=2 -> carry.
  function automatic logic [W-1:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] z);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      int n;
      n = int'(x[i]) + int'(y[i]) + int'(z[i]);
      r[i] = (n % 2) != 0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ref_carry(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      int n;
      n = int'(x[i]) + int'(y[i]) + int'(z[i]);
      r[i] = n >= 2;
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_carry"}, 64'(carry), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
`ifdef CSA_FINAL_ADD_EN
    check({tag, "_total"}, 64'(total), 64'd0);
`endif
  endtask

  // Drive one valid vector and check the registered result one edge later.
  task automatic apply(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] z);
    logic [63:0] exp_total;
    @(negedge clk);
    a = x; b = y; cin = z; in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_total = 64'(x) + 64'(y) + 64'(z);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(ref_sum(x, y, z)));
    check({tag, "_carry"}, 64'(carry), 64'(ref_carry(x, y, z)));
    check({tag, "_inv"}, 64'(sum) + (64'(carry) << 1), exp_total);
`ifdef CSA_FINAL_ADD_EN
    check({tag, "_total"}, 64'(total), exp_total);
`endif
  endtask

  initial begin
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    apply("d1", 8'h01, 8'h02, 8'h03);
    check("d1_sum_k", 64'(sum), 64'h00);
    check("d1_carry_k", 64'(carry), 64'h03);
    apply("d2", 8'hF0, 8'h0F, 8'hAA);
    check("d2_sum_k", 64'(sum), 64'h55);
    check("d2_carry_k", 64'(carry), 64'hAA);
    apply("d3", 8'hAA, 8'h55, 8'hCC);
    check("d3_sum_k", 64'(sum), 64'h33);
    check("d3_carry_k", 64'(carry), 64'hCC);
    apply("dmax", 8'hFF, 8'hFF, 8'hFF);
    check("dmax_sum_k", 64'(sum), 64'hFF);
    check("dmax_carry_k", 64'(carry), 64'hFF);
`ifdef CSA_FINAL_ADD_EN
    check("dmax_total_k", 64'(total), 64'd765);
`endif

    apply("dh", 8'h00, 8'h01, 8'h02);
    check("dh_sum_k", 64'(sum), 64'h03);
    check("dh_carry_k", 64'(carry), 64'h00);
    // Idle cycles: result holds, out_valid drops.
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h5A; b = 8'hC3; cin = 8'h99;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd0);
      check("hold_sum", 64'(sum), 64'h03);
      check("hold_carry", 64'(carry), 64'h00);
`ifdef CSA_FINAL_ADD_EN
      check("hold_total", 64'(total), 64'd3);
`endif
    end

    // Reset pulse entirely between edges must clear outputs asynchronously.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("apulse");
    #1 rst = 1'b0;

    // Reset held across an edge discards the in-flight vector.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 8'h56; in_valid = 1'b1;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_valid", 64'(out_valid), 64'd1);
    check("post_sum", 64'(sum), 64'(ref_sum(8'h12, 8'h34, 8'h56)));
    check("post_carry", 64'(carry), 64'(ref_carry(8'h12, 8'h34, 8'h56)));

    for (int n = 0; n < 1000; n++) begin
      apply("rnd", W'($urandom), W'($urandom), W'($urandom));
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("end_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
